burst_beamformer: RTL and testbench

- Generalised N-channel ultrasonic transmit beamformer. Emits periodic bursts of a square-wave carrier on every channel.
- Each channel's burst start is delayed by a true time delay, not a phase modulo, that steers the beam by sin(theta).
- New steering angles arrive over a valid/ready handshake. Delays are computed sequentially with one shared multiplier and applied atomically at the next period boundary.
- Sits between the angle-sweep controller and the transducer drivers. Its period_start output times the receive path.

---
 rtl/beamformer_pkg.sv | 17 +
 rtl/tx_channel.sv | 54 +++++
 rtl/burst_beamformer.sv | 160 ++++++++++++++++
 tb/tb_burst_beamformer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/beamformer_pkg.sv
// Shared types and elaboration-time helpers for the burst beamformer.
package beamformer_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, ARMED} state_t;

  // Clock cycles of propagation delay per element pitch, truncated.
  function automatic int calc_dpe(input longint spacing, input longint clk_freq,
                                  input longint sos);
    return int'((spacing * clk_freq) / sos);
  endfunction

  // Full width of (DPE*k) * sin_value, so the product never overflows.
  function automatic int calc_prod_width(input int sin_width, input int dpe, input int n);
    return sin_width + $clog2(dpe * n);
  endfunction

endpackage

// File: rtl/tx_channel.sv
// One transducer channel: burst window compare plus a free-running carrier phase
// counter restarted at the channel's delay, then a registered drive output.
module tx_channel #(
  parameter int T_WIDTH      = 24,
  parameter int DELAY_WIDTH  = 16,
  parameter int BURST_CYCLES = 524288,
  parameter int WAVE_PERIOD  = 2500,
  parameter int WAVE_HIGH    = 1250
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   enable,
  input  logic [T_WIDTH-1:0]     t,
  input  logic [DELAY_WIDTH-1:0] delay,
  output logic                   in_window,
  output logic                   tx
);

  localparam int CW  = (T_WIDTH > DELAY_WIDTH ? T_WIDTH : DELAY_WIDTH) + 2;
  localparam int PHW = $clog2(WAVE_PERIOD);

  logic [CW-1:0]  t_w;
  logic [CW-1:0]  start_w;
  logic [CW-1:0]  end_w;
  logic [PHW-1:0] phase_reg;
  logic           in_window_reg;
  logic           tx_reg;

  assign t_w     = CW'(t);
  assign start_w = CW'(delay);
  assign end_w   = CW'(delay) + CW'(BURST_CYCLES);

  // Stage 1 tracks t; stage 2 turns window and phase into the drive level.
  always_ff @(posedge clk) begin
    if (srst || !enable) begin
      in_window_reg <= 1'b0;
      phase_reg     <= '0;
      tx_reg        <= 1'b0;
    end else begin
      in_window_reg <= (t_w >= start_w) && (t_w < end_w);
      if (t_w == start_w)
        phase_reg <= '0;
      else if (phase_reg == PHW'(WAVE_PERIOD - 1))
        phase_reg <= '0;
      else
        phase_reg <= phase_reg + PHW'(1);
      tx_reg <= in_window_reg && (phase_reg < PHW'(WAVE_HIGH));
    end
  end

  assign in_window = in_window_reg;
  assign tx        = tx_reg;

endmodule

// File: rtl/burst_beamformer.sv
// N-channel transmit beamformer: period counter, sequential delay computation with a
// single multiplier, and atomic delay update at the period boundary.
module burst_beamformer
  import beamformer_pkg::*;
#(
  parameter int NUM_TRANSMITTERS = 4,
  parameter int PERIOD_CYCLES    = 16777216,
  parameter int BURST_CYCLES     = 524288,
  parameter int WAVE_PERIOD      = 2500,
  parameter int WAVE_HIGH        = 1250,
  parameter int ELEMENT_SPACING  = 9,
  parameter int SPEED_OF_SOUND   = 343000,
  parameter int CLK_FREQ         = 100000000,
  parameter int SIN_WIDTH        = 17,
  parameter int DELAY_WIDTH      = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        enable,
  input  logic                        angle_valid,
  output logic                        angle_ready,
  input  logic [SIN_WIDTH-1:0]        sin_value,
  input  logic                        sign_bit,
  output logic [NUM_TRANSMITTERS-1:0] tx_out,
  output logic                        period_start,
  output logic                        burst_active
);

  localparam int DPE = calc_dpe(ELEMENT_SPACING, CLK_FREQ, SPEED_OF_SOUND);
  localparam int KW  = $clog2(DPE * NUM_TRANSMITTERS);
  localparam int PW  = calc_prod_width(SIN_WIDTH, DPE, NUM_TRANSMITTERS);
  localparam int TW  = $clog2(PERIOD_CYCLES);
  localparam int CHW = $clog2(NUM_TRANSMITTERS);
  localparam longint MAX_DELAY =
    (longint'(DPE) * (NUM_TRANSMITTERS - 1) * ((longint'(1) << SIN_WIDTH) - 1)) >> (SIN_WIDTH - 1);

  if (longint'(DPE) * (NUM_TRANSMITTERS - 1) + BURST_CYCLES >= PERIOD_CYCLES) begin : g_bad_timing
    $error("steering span plus burst does not fit in the period");
  end
  if (MAX_DELAY >= (longint'(1) << DELAY_WIDTH)) begin : g_bad_width
    $error("largest delay does not fit DELAY_WIDTH");
  end

  state_t                 state_reg;
  logic                   ready_reg;
  logic [SIN_WIDTH-1:0]   sin_reg;
  logic                   sign_reg;
  logic [KW-1:0]          dpe_k_reg;
  logic [CHW-1:0]         ch_reg;
  logic                   pending_flag_reg;
  logic [DELAY_WIDTH-1:0] pending_reg [NUM_TRANSMITTERS];
  logic [DELAY_WIDTH-1:0] active_reg  [NUM_TRANSMITTERS];
  logic [DELAY_WIDTH-1:0] delay_use   [NUM_TRANSMITTERS];
  logic [TW-1:0]          t_reg;
  logic                   period_start_reg;
  logic                   burst_active_reg;
  logic [NUM_TRANSMITTERS-1:0] in_window;
  logic                   copy;

  // With enable low t is already 0, so a pending set is taken over straight away.
  assign copy = pending_flag_reg && (!enable || (t_reg == '0));

  // dpe_k_reg walks DPE*k up or down, leaving sin_value as the only multiplier operand.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg        <= IDLE;
      ready_reg        <= 1'b1;
      sin_reg          <= '0;
      sign_reg         <= 1'b0;
      dpe_k_reg        <= '0;
      ch_reg           <= '0;
      pending_flag_reg <= 1'b0;
      for (int i = 0; i < NUM_TRANSMITTERS; i++) begin
        pending_reg[i] <= '0;
        active_reg[i]  <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (angle_valid && ready_reg) begin
            sin_reg   <= sin_value;
            sign_reg  <= sign_bit;
            dpe_k_reg <= sign_bit ? KW'(DPE * (NUM_TRANSMITTERS - 1)) : '0;
            ch_reg    <= '0;
            ready_reg <= 1'b0;
            state_reg <= COMPUTE;
          end
        end
        COMPUTE: begin
          pending_reg[ch_reg] <=
            DELAY_WIDTH'((PW'(dpe_k_reg) * PW'(sin_reg)) >> (SIN_WIDTH - 1));
          dpe_k_reg <= sign_reg ? dpe_k_reg - KW'(DPE) : dpe_k_reg + KW'(DPE);
          ch_reg    <= ch_reg + CHW'(1);
          if (ch_reg == CHW'(NUM_TRANSMITTERS - 1)) begin
            pending_flag_reg <= 1'b1;
            state_reg        <= ARMED;
          end
        end
        ARMED: begin
          if (copy) begin
            for (int i = 0; i < NUM_TRANSMITTERS; i++)
              active_reg[i] <= pending_reg[i];
            pending_flag_reg <= 1'b0;
            ready_reg        <= 1'b1;
            state_reg        <= IDLE;
          end
        end
        default: begin
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || !enable)
      t_reg <= '0;
    else if (t_reg == TW'(PERIOD_CYCLES - 1))
      t_reg <= '0;
    else
      t_reg <= t_reg + TW'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      period_start_reg <= 1'b0;
      burst_active_reg <= 1'b0;
    end else begin
      period_start_reg <= enable && (t_reg == '0);
      burst_active_reg <= enable && (|in_window);
    end
  end

  // Channels see the incoming set during the t=0 cycle that commits it.
  for (genvar gi = 0; gi < NUM_TRANSMITTERS; gi++) begin : g_ch
    assign delay_use[gi] = copy ? pending_reg[gi] : active_reg[gi];

    tx_channel #(
      .T_WIDTH     (TW),
      .DELAY_WIDTH (DELAY_WIDTH),
      .BURST_CYCLES(BURST_CYCLES),
      .WAVE_PERIOD (WAVE_PERIOD),
      .WAVE_HIGH   (WAVE_HIGH)
    ) u_ch (
      .clk      (clk_in),
      .srst     (rst_in),
      .enable   (enable),
      .t        (t_reg),
      .delay    (delay_use[gi]),
      .in_window(in_window[gi]),
      .tx       (tx_out[gi])
    );
  end

  assign angle_ready  = ready_reg;
  assign period_start = period_start_reg;
  assign burst_active = burst_active_reg;

endmodule

// File: tb/tb_burst_beamformer.sv
// Directed bench for burst_beamformer: per-period edge measurements against
// hand-computed delays, plus enable-drop and reset-during-compute sequences.
module tb_burst_beamformer;

  localparam int N      = 4;
  localparam int PERIOD = 20000;
  localparam int BURST  = 5000;
  localparam int INJ    = 100;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        enable;
  logic        angle_valid;
  logic        angle_ready;
  logic [16:0] sin_value;
  logic        sign_bit;
  logic [3:0]  tx_out;
  logic        period_start;
  logic        burst_active;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [16:0] sin;
    logic        sign;
    int          d0, d1, d2, d3;
  } vec_t;

  vec_t vecs [3];
  int   prev [4];

  always #5 clk = ~clk;

  burst_beamformer #(
    .NUM_TRANSMITTERS(N),
    .PERIOD_CYCLES   (PERIOD),
    .BURST_CYCLES    (BURST)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .enable      (enable),
    .angle_valid (angle_valid),
    .angle_ready (angle_ready),
    .sin_value   (sin_value),
    .sign_bit    (sign_bit),
    .tx_out      (tx_out),
    .period_start(period_start),
    .burst_active(burst_active)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Entered at the sample where period_start is high (offset 0); leaves at the next one.
  task automatic measure(input int exp_d[4], input bit inject, input logic [16:0] s,
                         input logic sg, input int p);
    int first_rise[4];
    int last_high[4];
    int highs[4];
    int rises[4];
    int ba_cnt = 0;
    int ps_cnt = 0;
    int dmin = exp_d[0];
    int dmax = exp_d[0];
    logic [3:0] prv = 4'b0;
    bit low_ok = 1'b1;
    for (int ch = 0; ch < N; ch++) begin
      first_rise[ch] = -1; last_high[ch] = -1; highs[ch] = 0; rises[ch] = 0;
      if (exp_d[ch] < dmin) dmin = exp_d[ch];
      if (exp_d[ch] > dmax) dmax = exp_d[ch];
    end
    for (int c = 0; c < PERIOD; c++) begin
      if (c > 0) @(negedge clk);
      for (int ch = 0; ch < N; ch++) begin
        if (tx_out[ch]) begin
          highs[ch]++;
          last_high[ch] = c;
          if (!prv[ch]) begin
            rises[ch]++;
            if (first_rise[ch] < 0) first_rise[ch] = c;
          end
        end
      end
      prv = tx_out;
      if (burst_active) ba_cnt++;
      if (c > 0 && period_start) ps_cnt++;
      if (inject) begin
        if (c == INJ) begin
          check($sformatf("p%0d_ready_before_offer", p), int'(angle_ready), 1);
          angle_valid = 1'b1; sin_value = s; sign_bit = sg;
        end
        if (c == INJ + 1) angle_valid = 1'b0;
        if (c > INJ && c <= INJ + 6 && angle_ready) low_ok = 1'b0;
        if (c == PERIOD - 1)
          check($sformatf("p%0d_ready_armed_last_cycle", p), int'(angle_ready), 0);
      end
    end
    for (int ch = 0; ch < N; ch++) begin
      check($sformatf("p%0d_rise_ch%0d", p, ch), first_rise[ch], exp_d[ch] + 1);
      check($sformatf("p%0d_last_high_ch%0d", p, ch), last_high[ch], exp_d[ch] + 3750);
      check($sformatf("p%0d_high_cycles_ch%0d", p, ch), highs[ch], 2500);
      check($sformatf("p%0d_rise_count_ch%0d", p, ch), rises[ch], 2);
    end
    check($sformatf("p%0d_burst_active_cycles", p), ba_cnt, dmax - dmin + BURST);
    check($sformatf("p%0d_no_extra_period_start", p), ps_cnt, 0);
    if (inject) check($sformatf("p%0d_ready_low_during_compute", p), int'(low_ok), 1);
    @(negedge clk);
    check($sformatf("p%0d_period_start_at_boundary", p), int'(period_start), 1);
    if (inject) check($sformatf("p%0d_ready_at_boundary", p), int'(angle_ready), 1);
  endtask

  initial begin
    int n;
    int r;
    rst_in = 1'b1; enable = 1'b0; angle_valid = 1'b0; sin_value = '0; sign_bit = 1'b0;

    vecs[0] = '{sin: 17'd32768, sign: 1'b0, d0: 0,    d1: 1311, d2: 2623, d3: 3934};
    vecs[1] = '{sin: 17'd32768, sign: 1'b1, d0: 3934, d1: 2623, d2: 1311, d3: 0};
    vecs[2] = '{sin: 17'd65535, sign: 1'b0, d0: 0,    d1: 2622, d2: 5245, d3: 7868};

    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    check("reset_tx_out", int'(tx_out), 0);
    check("reset_period_start", int'(period_start), 0);
    check("reset_burst_active", int'(burst_active), 0);
    check("reset_angle_ready", int'(angle_ready), 1);

    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 10);
    check("first_period_start_latency", n, 1);

    prev = '{0, 0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      measure(prev, 1'b1, vecs[i].sin, vecs[i].sign, i);
      prev = '{vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3};
    end
    measure(prev, 1'b0, 17'd0, 1'b0, 3);

    // Drop enable mid-burst while channel 0 is high.
    repeat (2600) @(negedge clk);
    check("pre_disable_tx_out", int'(tx_out), 4'b0001);
    check("pre_disable_burst_active", int'(burst_active), 1);
    enable = 1'b0;
    @(negedge clk);
    check("disable_tx_out", int'(tx_out), 0);
    check("disable_burst_active", int'(burst_active), 0);
    n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (period_start || tx_out != 4'b0) n++;
    end
    check("disabled_outputs_quiet", n, 0);

    enable = 1'b1;
    @(negedge clk);
    check("reenable_period_start", int'(period_start), 1);
    check("reenable_tx_idle", int'(tx_out), 0);
    @(negedge clk);
    check("reenable_ch0_rise", int'(tx_out), 4'b0001);
    r = -1;
    for (int c = 2; c <= 2700; c++) begin
      @(negedge clk);
      if (tx_out[1] && r < 0) r = c;
    end
    check("reenable_ch1_rise", r, 2623);

    // Reset in the middle of computing a new set: nothing of it survives.
    angle_valid = 1'b1; sin_value = 17'd65535; sign_bit = 1'b1;
    @(negedge clk);
    angle_valid = 1'b0;
    check("compute_ready_low", int'(angle_ready), 0);
    @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    check("post_reset_ready", int'(angle_ready), 1);
    check("post_reset_tx_out", int'(tx_out), 0);
    check("post_reset_period_start_low", int'(period_start), 0);
    @(negedge clk);
    check("post_reset_period_start", int'(period_start), 1);
    @(negedge clk);
    check("post_reset_broadside", int'(tx_out), 4'b1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
